ins_fill_responder: RTL

Next-level memory responder that services line-fill requests issued by the instruction cache on a miss. Accepts 26-bit line addresses (byte address bits [31:6]) through a valid/ready handshake into a small request FIFO. Services them in order: after a fixed access latency, returns each 64-byte line as 16 beats of 32-bit data. Sits between the instruction cache's miss path and the statistics module, and provides a deterministic memory model for trace-driven simulation.

---
 rtl/ins_fill_responder_if.sv | 28 ++
 rtl/ins_fill_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ins_fill_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ins_fill_responder_if
// Purpose : Line-fill request/response channel between I-cache and responder.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface ins_fill_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [25:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [25:0] rsp_addr;
  logic [3:0]  rsp_beat;
  logic [31:0] rsp_data;
  logic        rsp_last;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_beat, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_beat, rsp_data, rsp_last
  );
endinterface
`default_nettype wire

// File: rtl/ins_fill_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ins_fill_responder
// Purpose : In-order line-fill memory model: request FIFO, fixed latency, 16 beats.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module ins_fill_responder #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8,
  parameter int BEATS   = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  ins_fill_responder_if.slave    bus,
  output logic                   busy,
  output logic [31:0]            accepted,
  output logic [31:0]            fills
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [15:0]   C_LAT_INIT  = 16'(LATENCY - 1);
  localparam logic [3:0]    C_LAST_BEAT = 4'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  logic [25:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [15:0]   r_lat_cnt;
  logic [3:0]    r_beat;
  logic [25:0]   r_addr;
  logic [31:0]   r_accepted;
  logic [31:0]   r_fills;

  state_t        w_state_nxt;
  logic [15:0]   w_lat_nxt;
  logic [3:0]    w_beat_nxt;
  logic [25:0]   w_addr_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_fill_done;
  logic          w_send;
  logic          w_last;

  // Ready depends only on the registered count, so a pop frees space one cycle later.
  assign bus.req_ready = (r_count < C_DEPTH);
  assign w_push        = bus.req_valid && bus.req_ready;
  assign w_send        = (r_state == S_SEND);
  assign w_last        = w_send && (r_beat == C_LAST_BEAT);

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_beat_nxt  = r_beat;
    w_addr_nxt  = r_addr;
    w_pop       = 1'b0;
    w_fill_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_addr_nxt  = r_mem[r_rd_ptr];
          w_lat_nxt   = C_LAT_INIT;
          w_beat_nxt  = 4'd0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == 16'd0) begin
          w_state_nxt = S_SEND;
        end else begin
          w_lat_nxt = r_lat_cnt - 16'd1;
        end
      end
      S_SEND: begin
        if (bus.rsp_ready) begin
          if (w_last) begin
            w_fill_done = 1'b1;
            w_beat_nxt  = 4'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_nxt = r_beat + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= 16'd0;
      r_beat     <= 4'd0;
      r_addr     <= 26'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_accepted <= 32'd0;
      r_fills    <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_beat    <= w_beat_nxt;
      r_addr    <= w_addr_nxt;
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PW'(1);
        r_accepted <= r_accepted + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_fill_done) begin
        r_fills <= r_fills + 32'd1;
      end
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.req_addr;
    end
  end

  assign bus.rsp_valid = w_send;
  assign bus.rsp_addr  = r_addr;
  assign bus.rsp_beat  = r_beat;
  assign bus.rsp_data  = w_send ? {r_addr, r_beat, 2'b00} : 32'd0;
  assign bus.rsp_last  = w_last;
  assign busy          = (r_count != '0) || (r_state != S_IDLE);
  assign accepted      = r_accepted;
  assign fills         = r_fills;

endmodule
`default_nettype wire
